// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM states and a frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int frame_cycles(int clks, int data, int par, int stop);
    return clks * (1 + data + ((par != PAR_NONE) ? 1 : 0) + stop);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side write port and line-side status of the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          i_Tx_DV;
  logic [DATA_BITS-1:0]          i_Tx_Byte;
  logic                          o_Tx_Ready;
  logic                          o_Tx_Overflow;
  logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count;
  logic                          o_Tx_Active;
  logic                          o_Tx_Serial;
  logic                          o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Overflow, o_Fifo_Count, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count; head word is read from storage, never bypassed from the input.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_C = AW1'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // Full is taken from the registered count, so a pop cannot make room for a same-cycle write.
  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; queued frames leave back-to-back with no idle gap.
// All outputs are registered; a write while full is dropped and flagged one cycle later.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_fifo_if.slave tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e              state_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [BW-1:0]          bit_idx_q;
  logic                   stop_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q, serial_q, active_q, done_q, ovf_q;

  logic [DATA_BITS-1:0]        fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full, fifo_empty;
  logic                        bit_end, stop_end, pop_d, par_d;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .wr_en_i   (tx.i_Tx_DV),
    .wr_data_i (tx.i_Tx_Byte),
    .rd_en_i   (pop_d),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bit_end  = (clk_cnt_q == CLK_LAST);
  assign stop_end = (state_q == ST_STOP) && bit_end && (stop_cnt_q == STOP_LAST);
  // Pop from IDLE, or on the last stop cycle so the next start bit follows without a gap.
  assign pop_d    = !fifo_empty && ((state_q == ST_IDLE) || stop_end);
  assign par_d    = (PARITY == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;

  assign tx.o_Tx_Ready    = !fifo_full;
  assign tx.o_Fifo_Count  = fifo_count;
  assign tx.o_Tx_Overflow = ovf_q;
  assign tx.o_Tx_Active   = active_q;
  assign tx.o_Tx_Serial   = serial_q;
  assign tx.o_Tx_Done     = done_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= tx.i_Tx_DV && fifo_full;
      if (pop_d) begin
        state_q    <= ST_START;
        shift_q    <= fifo_rd_data;
        par_q      <= par_d;
        clk_cnt_q  <= '0;
        bit_idx_q  <= '0;
        stop_cnt_q <= 1'b0;
        serial_q   <= 1'b0;
        active_q   <= 1'b1;
        done_q     <= (state_q == ST_STOP);
      end else begin
        clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;
        case (state_q)
          ST_IDLE: begin
            clk_cnt_q <= '0;
            serial_q  <= 1'b1;
          end
          ST_START: begin
            if (bit_end) begin
              state_q  <= ST_DATA;
              serial_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              if (bit_idx_q != BIT_LAST) begin
                bit_idx_q <= bit_idx_q + 1'b1;
                serial_q  <= shift_q[0];
                shift_q   <= shift_q >> 1;
              end else if (PARITY != PAR_NONE) begin
                state_q  <= ST_PARITY;
                serial_q <= par_q;
              end else begin
                state_q  <= ST_STOP;
                serial_q <= 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_end) begin
              state_q  <= ST_STOP;
              serial_q <= 1'b1;
            end
          end
          ST_STOP: begin
            if (stop_end) begin
              state_q  <= ST_IDLE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end else if (bit_end) begin
              stop_cnt_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
